// File: rtl/ocs_ctrl_pkg.sv
// Shared types and default timing for the OCS controller slot scheduler.
// Optional statistics in the top are enabled with SLOT_SCHED_STAT_EN.
package ocs_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, SYNC, SLOT, CONFIG} state_t;

  localparam logic SYNC_TIME  = 1'b0;
  localparam logic SYNC_START = 1'b1;

  localparam int          DEF_CHANNEL_NUM  = 8;
  localparam logic [31:0] DEF_SLOT_LEN     = 32'h0000_0753;
  localparam logic [31:0] DEF_CONFIG_DELAY = 32'h0000_00AA;
  localparam int          DEF_SLOT_NUM     = 2;
  localparam logic [15:0] DEF_LINK_STABLE  = 16'd1000;
  localparam logic [15:0] DEF_SYNC_TIMEOUT = 16'd4096;

  function automatic int slot_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ocs_sync_collector.sv
// Per-channel sync request tracking: set-all on start, clear-on-ack,
// all-acked detection and the sync timeout counter.
module ocs_sync_collector
  import ocs_ctrl_pkg::*;
#(
  parameter int          P_CHANNEL_NUM  = DEF_CHANNEL_NUM,
  parameter logic [15:0] P_SYNC_TIMEOUT = DEF_SYNC_TIMEOUT
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_clear,
  input  logic                     i_en,
  input  logic [P_CHANNEL_NUM-1:0] i_ack,
  output logic [P_CHANNEL_NUM-1:0] o_req,
  output logic                     o_done,
  output logic                     o_timeout
);

  localparam logic [31:0] TO_TC = 32'(P_SYNC_TIMEOUT) - 32'd1;

  logic [P_CHANNEL_NUM-1:0] r_req;
  logic [31:0]              r_cnt;
  logic [P_CHANNEL_NUM-1:0] w_pending;

  // An ack landing on the timeout cycle still clears its request, so a
  // last ack coincident with the timeout is treated as success.
  assign w_pending = r_req & ~i_ack;
  assign o_timeout = i_en && (r_cnt == TO_TC) && (|w_pending);
  assign o_done    = ~|r_req;
  assign o_req     = r_req;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_req <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_req <= '1;
      r_cnt <= '0;
    end else if (i_en) begin
      if (o_timeout) begin
        r_req <= '0;
        r_cnt <= '0;
      end else begin
        r_req <= w_pending;
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/ocs_slot_scheduler.sv
// OCS slot sequencer: link-stable wait, sync handshake, data slot, reconfig.
// Define SLOT_SCHED_STAT_EN to add the o_slot_cnt / o_err_cnt statistics.
module ocs_slot_scheduler
  import ocs_ctrl_pkg::*;
#(
  parameter int          P_CHANNEL_NUM  = DEF_CHANNEL_NUM,
  parameter logic [31:0] P_SLOT_LEN     = DEF_SLOT_LEN,
  parameter logic [31:0] P_CONFIG_DELAY = DEF_CONFIG_DELAY,
  parameter int          P_SLOT_NUM     = DEF_SLOT_NUM,
  parameter logic [15:0] P_LINK_STABLE  = DEF_LINK_STABLE,
  parameter logic [15:0] P_SYNC_TIMEOUT = DEF_SYNC_TIMEOUT
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [P_CHANNEL_NUM-1:0]            i_link_up,
  output logic [P_CHANNEL_NUM-1:0]            o_sync_req,
  output logic                                o_sync_type,
  input  logic [P_CHANNEL_NUM-1:0]            i_sync_ack,
  output logic [slot_id_w(P_SLOT_NUM)-1:0]    o_slot_id,
  output logic                                o_slot_active,
  output logic                                o_ocs_cfg,
`ifdef SLOT_SCHED_STAT_EN
  output logic [31:0]                         o_slot_cnt,
  output logic [15:0]                         o_err_cnt,
`endif
  output logic                                o_err
);

  localparam int                   SLOT_ID_W = slot_id_w(P_SLOT_NUM);
  localparam logic [31:0]          STAB_TC   = 32'(P_LINK_STABLE) - 32'd1;
  localparam logic [31:0]          SLOT_TC   = P_SLOT_LEN - 32'd1;
  localparam logic [31:0]          CFG_TC    = P_CONFIG_DELAY - 32'd1;
  localparam logic [SLOT_ID_W-1:0] LAST_ID   = SLOT_ID_W'(P_SLOT_NUM - 1);

  state_t                r_state;
  logic [31:0]           r_stab;
  logic [31:0]           r_cnt;
  logic                  r_started;
  logic                  r_slot_active;
  logic                  r_ocs_cfg;
  logic                  r_err;
  logic                  r_sync_type;
  logic [SLOT_ID_W-1:0]  r_slot_id;

  logic w_all_up, w_drop, w_start, w_done, w_timeout, w_sync_en, w_err_set;

  assign w_all_up  = &i_link_up;
  assign w_drop    = (r_state != IDLE) && !w_all_up;
  assign w_start   = (r_state == IDLE && w_all_up && r_stab == STAB_TC) ||
                     (r_state == CONFIG && w_all_up && r_cnt == CFG_TC);
  assign w_sync_en = (r_state == SYNC) && !w_drop;
  assign w_err_set = w_drop || w_timeout;

  ocs_sync_collector #(
    .P_CHANNEL_NUM  (P_CHANNEL_NUM),
    .P_SYNC_TIMEOUT (P_SYNC_TIMEOUT)
  ) u_sync (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (w_start),
    .i_clear   (w_drop),
    .i_en      (w_sync_en),
    .i_ack     (i_sync_ack),
    .o_req     (o_sync_req),
    .o_done    (w_done),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_stab        <= '0;
      r_cnt         <= '0;
      r_started     <= 1'b0;
      r_slot_active <= 1'b0;
      r_ocs_cfg     <= 1'b0;
      r_err         <= 1'b0;
      r_sync_type   <= SYNC_TIME;
      r_slot_id     <= '0;
    end else begin
      r_err <= w_err_set;
      // A link drop overrides any terminal count or final ack this cycle.
      if (w_drop) begin
        r_state       <= IDLE;
        r_stab        <= '0;
        r_cnt         <= '0;
        r_slot_active <= 1'b0;
        r_ocs_cfg     <= 1'b0;
        r_sync_type   <= SYNC_TIME;
      end else begin
        case (r_state)
          IDLE: begin
            if (!w_all_up) begin
              r_stab <= '0;
            end else if (r_stab == STAB_TC) begin
              r_stab      <= '0;
              r_state     <= SYNC;
              r_sync_type <= r_started ? SYNC_TIME : SYNC_START;
            end else begin
              r_stab <= r_stab + 32'd1;
            end
          end
          SYNC: begin
            if (w_done) begin
              r_state       <= SLOT;
              r_started     <= 1'b1;
              r_slot_active <= 1'b1;
              r_sync_type   <= SYNC_TIME;
              r_cnt         <= '0;
            end else if (w_timeout) begin
              r_state     <= IDLE;
              r_sync_type <= SYNC_TIME;
              r_stab      <= '0;
            end
          end
          SLOT: begin
            if (r_cnt == SLOT_TC) begin
              r_state       <= CONFIG;
              r_slot_active <= 1'b0;
              r_ocs_cfg     <= 1'b1;
              r_cnt         <= '0;
              r_slot_id     <= (r_slot_id == LAST_ID) ? '0 : r_slot_id + 1'b1;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          CONFIG: begin
            if (r_cnt == CFG_TC) begin
              r_state     <= SYNC;
              r_ocs_cfg   <= 1'b0;
              r_sync_type <= SYNC_TIME;
              r_cnt       <= '0;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef SLOT_SCHED_STAT_EN
  logic [31:0] r_slot_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_slot_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (r_state == SYNC && w_done && !w_drop) r_slot_cnt <= r_slot_cnt + 32'd1;
      if (w_err_set && r_err_cnt != 16'hFFFF)   r_err_cnt  <= r_err_cnt + 16'd1;
    end
  end

  assign o_slot_cnt = r_slot_cnt;
  assign o_err_cnt  = r_err_cnt;
`endif

  assign o_sync_type   = r_sync_type;
  assign o_slot_id     = r_slot_id;
  assign o_slot_active = r_slot_active;
  assign o_ocs_cfg     = r_ocs_cfg;
  assign o_err         = r_err;

endmodule

// File: tb/tb_ocs_slot_scheduler.sv
// Self-checking bench for ocs_slot_scheduler with randomized ack timing.
module tb_ocs_slot_scheduler;

  localparam int          CH   = 4;
  localparam logic [31:0] LEN  = 32'd20;
  localparam logic [31:0] CFG  = 32'd5;
  localparam int          SN   = 2;
  localparam logic [15:0] STAB = 16'd8;
  localparam logic [15:0] TO   = 16'd32;
  localparam int          SW   = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] link;
  logic [CH-1:0] ack;
  logic [CH-1:0] o_sync_req;
  logic          o_sync_type;
  logic [SW-1:0] o_slot_id;
  logic          o_slot_active;
  logic          o_ocs_cfg;
  logic          o_err;
`ifdef SLOT_SCHED_STAT_EN
  logic [31:0]   o_slot_cnt;
  logic [15:0]   o_err_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int m_id   = 0;

  always #5 clk = ~clk;

  ocs_slot_scheduler #(
    .P_CHANNEL_NUM  (CH),
    .P_SLOT_LEN     (LEN),
    .P_CONFIG_DELAY (CFG),
    .P_SLOT_NUM     (SN),
    .P_LINK_STABLE  (STAB),
    .P_SYNC_TIMEOUT (TO)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_link_up     (link),
    .o_sync_req    (o_sync_req),
    .o_sync_type   (o_sync_type),
    .i_sync_ack    (ack),
    .o_slot_id     (o_slot_id),
    .o_slot_active (o_slot_active),
    .o_ocs_cfg     (o_ocs_cfg),
`ifdef SLOT_SCHED_STAT_EN
    .o_slot_cnt    (o_slot_cnt),
    .o_err_cnt     (o_err_cnt),
`endif
    .o_err         (o_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one sync handshake starting just after the SYNC-entry edge.
  // Channel n acks on handshake cycle dly[n]+1 (dly<0: never). The model:
  // a request drops the cycle after its ack, SLOT follows one cycle after
  // the last request drops, and an outstanding request on cycle TO is an error.
  task automatic sync_phase(input int dly[CH], output int bad, output int lat, output bit tmo);
    int            dmax;
    bit            never;
    logic [CH-1:0] exp_req;
    logic [CH-1:0] a;
    bad = 0; lat = -1; tmo = 1'b0; dmax = 0; never = 1'b0;
    for (int n = 0; n < CH; n++) begin
      if (dly[n] < 0) never = 1'b1;
      else if (dly[n] > dmax) dmax = dly[n];
    end
    for (int j = 1; j <= int'(TO) + 4; j++) begin
      for (int n = 0; n < CH; n++)
        a[n] = (dly[n] == j - 1) || (dly[n] >= 0 && j - 1 > dly[n] && $urandom_range(0, 3) == 0);
      ack = a;
      tick();
      ack = '0;
      for (int n = 0; n < CH; n++) exp_req[n] = !(dly[n] >= 0 && j >= dly[n] + 1);
      if (!never && j == dmax + 2) begin
        if (o_slot_active !== 1'b1 || o_sync_req !== '0 || o_err !== 1'b0) bad++;
        lat = j;
        break;
      end else if (exp_req != '0 && j == int'(TO)) begin
        tmo = 1'b1;
        if (o_err !== 1'b1 || o_sync_req !== '0 || o_slot_active !== 1'b0) bad++;
        break;
      end else if (o_sync_req !== exp_req || o_err !== 1'b0 || o_slot_active !== 1'b0) begin
        bad++;
      end
    end
  endtask

  task automatic run_slot_cfg(output int act_n, output int cfg_n, output logic [SW-1:0] id_cfg);
    act_n = 0;
    while (o_slot_active === 1'b1 && act_n < 200) begin act_n++; tick(); end
    id_cfg = o_slot_id;
    cfg_n = 0;
    while (o_ocs_cfg === 1'b1 && cfg_n < 200) begin cfg_n++; tick(); end
  endtask

  task automatic test_reset();
    rst = 1'b1; link = '0; ack = '0;
    tick(); tick();
    checks++; if (o_sync_req !== '0) begin errors++; $display("FAIL reset_req: got %h want 0", o_sync_req); end
    checks++; if (o_sync_type !== 1'b0 || o_err !== 1'b0) begin errors++; $display("FAIL reset_type_err: got %b%b want 00", o_sync_type, o_err); end
    checks++; if (o_slot_active !== 1'b0 || o_ocs_cfg !== 1'b0 || o_slot_id !== '0) begin
      errors++; $display("FAIL reset_slot: got act=%b cfg=%b id=%h want 0", o_slot_active, o_ocs_cfg, o_slot_id); end
`ifdef SLOT_SCHED_STAT_EN
    checks++; if (o_slot_cnt !== '0 || o_err_cnt !== '0) begin errors++; $display("FAIL reset_stat: got %0d %0d want 0", o_slot_cnt, o_err_cnt); end
`endif
    rst = 1'b0; m_id = 0;
  endtask

  task automatic test_startup();
    int d[CH]; int bad, lat, an, cn, early; bit tmo; logic [SW-1:0] idc;
    link = '1; early = 0;
    for (int i = 1; i < int'(STAB); i++) begin tick(); if (o_sync_req !== '0) early++; end
    checks++; if (early !== 0) begin errors++; $display("FAIL start_early: got %0d early reqs want 0", early); end
    tick();
    checks++; if (o_sync_req !== 4'hF) begin errors++; $display("FAIL start_req: got %h want f", o_sync_req); end
    checks++; if (o_sync_type !== 1'b1) begin errors++; $display("FAIL start_type: got %b want 1", o_sync_type); end
    d = '{0, 0, 0, 0};
    sync_phase(d, bad, lat, tmo);
    checks++; if (bad !== 0 || lat !== 2) begin errors++; $display("FAIL start_sync: got bad=%0d lat=%0d want 0/2", bad, lat); end
    run_slot_cfg(an, cn, idc);
    m_id = (m_id + 1) % SN;
    checks++; if (an !== int'(LEN)) begin errors++; $display("FAIL start_slot_len: got %0d want %0d", an, LEN); end
    checks++; if (cn !== int'(CFG)) begin errors++; $display("FAIL start_cfg_len: got %0d want %0d", cn, CFG); end
    checks++; if (idc !== SW'(m_id)) begin errors++; $display("FAIL start_slot_id: got %0d want %0d", idc, m_id); end
  endtask

  task automatic test_steady();
    int d[CH]; int bad, lat, an, cn, dmax; bit tmo; logic [SW-1:0] idc;
    for (int p = 0; p < 2; p++) begin
      checks++; if (o_sync_req !== 4'hF || o_sync_type !== 1'b0) begin
        errors++; $display("FAIL steady_sync_entry: got req=%h type=%b want f/0", o_sync_req, o_sync_type); end
      dmax = 0;
      for (int n = 0; n < CH; n++) begin d[n] = $urandom_range(0, 6); if (d[n] > dmax) dmax = d[n]; end
      sync_phase(d, bad, lat, tmo);
      checks++; if (bad !== 0 || lat !== dmax + 2) begin errors++; $display("FAIL steady_sync: got bad=%0d lat=%0d want 0/%0d", bad, lat, dmax + 2); end
      run_slot_cfg(an, cn, idc);
      m_id = (m_id + 1) % SN;
      checks++; if (an !== int'(LEN) || cn !== int'(CFG)) begin errors++; $display("FAIL steady_len: got %0d/%0d want %0d/%0d", an, cn, LEN, CFG); end
      checks++; if (idc !== SW'(m_id)) begin errors++; $display("FAIL steady_slot_id: got %0d want %0d", idc, m_id); end
    end
  endtask

  task automatic test_staggered();
    int d[CH]; int bad, lat, an, cn; bit tmo; logic [SW-1:0] idc;
    d = '{0, 0, 10, 0};
    sync_phase(d, bad, lat, tmo);
    checks++; if (bad !== 0) begin errors++; $display("FAIL stagger_req: got %0d bad cycles want 0", bad); end
    checks++; if (lat !== 12) begin errors++; $display("FAIL stagger_slot_start: got %0d want 12", lat); end
    run_slot_cfg(an, cn, idc);
    m_id = (m_id + 1) % SN;
    checks++; if (an !== int'(LEN) || cn !== int'(CFG) || idc !== SW'(m_id)) begin
      errors++; $display("FAIL stagger_period: got %0d/%0d/%0d want %0d/%0d/%0d", an, cn, idc, LEN, CFG, m_id); end
  endtask

  task automatic test_timeout();
    int d[CH]; int bad, lat, an, cn; bit tmo; logic [SW-1:0] idc;
    d = '{0, 0, 0, int'(TO) - 1};
    sync_phase(d, bad, lat, tmo);
    checks++; if (bad !== 0 || tmo !== 1'b0 || lat !== int'(TO) + 1) begin
      errors++; $display("FAIL late_ack_success: got bad=%0d tmo=%0d lat=%0d want 0/0/%0d", bad, tmo, lat, TO + 1); end
    run_slot_cfg(an, cn, idc);
    m_id = (m_id + 1) % SN;
    d = '{$urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), -1};
    sync_phase(d, bad, lat, tmo);
    checks++; if (bad !== 0 || tmo !== 1'b1) begin errors++; $display("FAIL timeout: got bad=%0d tmo=%0d want 0/1", bad, tmo); end
    for (int i = 1; i <= int'(STAB); i++) begin
      tick();
      if (i == 1) begin
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL timeout_err_pulse: got %b want 0", o_err); end
      end
      if (i < int'(STAB) && o_sync_req !== '0) begin
        checks++; errors++; $display("FAIL timeout_idle_req: got %h want 0", o_sync_req);
      end
    end
    checks++; if (o_sync_req !== 4'hF || o_sync_type !== 1'b0) begin
      errors++; $display("FAIL timeout_resync: got req=%h type=%b want f/0", o_sync_req, o_sync_type); end
    d = '{0, 0, 0, 0};
    sync_phase(d, bad, lat, tmo);
    checks++; if (bad !== 0 || lat !== 2) begin errors++; $display("FAIL timeout_resync_ack: got bad=%0d lat=%0d want 0/2", bad, lat); end
  endtask

  task automatic test_link_drop();
    int d[CH]; int bad, lat, early, g; bit tmo;
    repeat ($urandom_range(2, 15)) tick();
    link = 4'b1101;
    tick();
    checks++; if (o_slot_active !== 1'b0 || o_err !== 1'b1) begin
      errors++; $display("FAIL drop_resp: got act=%b err=%b want 0/1", o_slot_active, o_err); end
    checks++; if (o_slot_id !== SW'(m_id) || o_sync_req !== '0) begin
      errors++; $display("FAIL drop_hold: got id=%0d req=%h want %0d/0", o_slot_id, o_sync_req, m_id); end
    repeat ($urandom_range(1, 4)) tick();
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL drop_err_pulse: got %b want 0", o_err); end
    link = 4'hF;
    g = $urandom_range(1, int'(STAB) - 2);
    repeat (g) tick();
    link = 4'b1011;
    tick();
    link = 4'hF;
    early = 0;
    for (int i = 1; i < int'(STAB); i++) begin tick(); if (o_sync_req !== '0) early++; end
    checks++; if (early !== 0) begin errors++; $display("FAIL drop_glitch_early: got %0d early reqs want 0", early); end
    tick();
    checks++; if (o_sync_req !== 4'hF || o_sync_type !== 1'b0) begin
      errors++; $display("FAIL drop_resync: got req=%h type=%b want f/0", o_sync_req, o_sync_type); end
    d = '{$urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4)};
    sync_phase(d, bad, lat, tmo);
    checks++; if (bad !== 0 || tmo !== 1'b0) begin errors++; $display("FAIL drop_resync_ack: got bad=%0d tmo=%0d want 0/0", bad, tmo); end
  endtask

  task automatic test_reset_mid_config();
    int d[CH]; int bad, lat, n, early; bit tmo;
    n = 0;
    while (o_ocs_cfg !== 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (o_ocs_cfg !== 1'b1) begin errors++; $display("FAIL rst_cfg_wait: got %b want 1", o_ocs_cfg); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_id = 0;
    checks++; if (o_ocs_cfg !== 1'b0 || o_slot_active !== 1'b0 || o_slot_id !== '0) begin
      errors++; $display("FAIL rst_mid_cfg: got cfg=%b act=%b id=%0d want 0", o_ocs_cfg, o_slot_active, o_slot_id); end
    checks++; if (o_sync_req !== '0 || o_err !== 1'b0 || o_sync_type !== 1'b0) begin
      errors++; $display("FAIL rst_mid_cfg_sync: got req=%h err=%b type=%b want 0", o_sync_req, o_err, o_sync_type); end
`ifdef SLOT_SCHED_STAT_EN
    checks++; if (o_slot_cnt !== '0) begin errors++; $display("FAIL rst_slot_cnt: got %0d want 0", o_slot_cnt); end
`endif
    early = 0;
    for (int i = 1; i < int'(STAB); i++) begin tick(); if (o_sync_req !== '0) early++; end
    tick();
    checks++; if (early !== 0 || o_sync_req !== 4'hF || o_sync_type !== 1'b1) begin
      errors++; $display("FAIL rst_restart: got early=%0d req=%h type=%b want 0/f/1", early, o_sync_req, o_sync_type); end
    d = '{0, 1, 2, 3};
    sync_phase(d, bad, lat, tmo);
    checks++; if (bad !== 0 || lat !== 5 || o_slot_id !== '0) begin
      errors++; $display("FAIL rst_restart_slot: got bad=%0d lat=%0d id=%0d want 0/5/0", bad, lat, o_slot_id); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_steady();
    test_staggered();
    test_timeout();
    test_link_drop();
    test_reset_mid_config();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ocs_slot_scheduler.md
Name: ocs_slot_scheduler

Overview:
- Central slot sequencer inside the OCS controller, one instance driving all ToR-facing control channels.
- Waits until every channel link is stable, then issues a sim-start sync.
- Afterwards it repeats a fixed cycle: data slot (P_SLOT_LEN), OCS reconfiguration (P_CONFIG_DELAY), time sync to all ToRs.
- Drives o_slot_id to the OCS switch models and gives per-channel sync requests to the control trx ports.

Parameters:
- P_CHANNEL_NUM, 8, number of ToR control channels.
- P_SLOT_LEN, 32'h0000_0753, data-slot length in clocks (must be >= 2).
- P_CONFIG_DELAY, 32'h0000_00AA, OCS reconfiguration window in clocks (must be >= 1).
- P_SLOT_NUM, 2, number of distinct OCS slot configurations; o_slot_id wraps at P_SLOT_NUM-1.
- P_LINK_STABLE, 16'd1000, consecutive cycles all links must be up before leaving IDLE.
- P_SYNC_TIMEOUT, 16'd4096, maximum cycles to wait for all sync acks.

Ports:
- i_clk, input, 1, system clock.
- i_rst, input, 1, synchronous active-high reset.
- i_link_up, input, P_CHANNEL_NUM, per-channel link status; level signal.
- o_sync_req, output, P_CHANNEL_NUM, per-channel sync request; held high until acked.
- o_sync_type, output, 1, sync type: 1 = sim-start command, 0 = time sync. Valid while any o_sync_req is high.
- i_sync_ack, input, P_CHANNEL_NUM, per-channel one-cycle ack from the trx port.
- o_slot_id, output, $clog2(P_SLOT_NUM) (min 1), current OCS configuration index.
- o_slot_active, output, 1, high for exactly the P_SLOT_LEN cycles of each data slot.
- o_ocs_cfg, output, 1, high for exactly the P_CONFIG_DELAY cycles of each reconfiguration window.
- o_err, output, 1, one-cycle pulse on link drop or sync timeout.

Behaviour:
- Clock and reset:
  - Single clock.
  - Reset is synchronous and active-high.
  - Reset values: all outputs 0; state IDLE; all counters 0; the "started" flag is cleared.
- FSM states: IDLE, SYNC, SLOT, CONFIG. All outputs are registered and change on the same edge as the state.
- IDLE:
  - A stable counter increments while &i_link_up and clears to 0 whenever any link is down.
  - When the count reaches P_LINK_STABLE-1 with all links still up, go to SYNC.
  - Sync type for that SYNC entry: o_sync_type=1 if "started" is clear, else 0.
- SYNC:
  - On entry, set o_sync_req to all ones.
  - On i_sync_ack[n], clear o_sync_req[n] the next cycle. Acks on channels not currently requested are ignored.
  - The cycle after the last request clears, go to SLOT and set "started".
  - If a timeout counter reaches P_SYNC_TIMEOUT-1 before all acks arrive: pulse o_err, clear all requests, go to IDLE.
- SLOT:
  - o_slot_active=1; a counter runs 0..P_SLOT_LEN-1.
  - At terminal count, go to CONFIG. On that same edge, o_slot_id <= (o_slot_id==P_SLOT_NUM-1) ? 0 : o_slot_id+1.
- CONFIG:
  - o_ocs_cfg=1; a counter runs 0..P_CONFIG_DELAY-1.
  - At terminal count, go to SYNC with o_sync_type=0.
- Period: one full period = P_SLOT_LEN + P_CONFIG_DELAY + sync handshake cycles.
- Link drop: any i_link_up bit low in SYNC/SLOT/CONFIG gives:
  - o_err pulse and return to IDLE;
  - all outputs cleared except o_slot_id (held);
  - "started" stays set, so re-entry issues a time sync (type 0), not sim-start.
- Simultaneous events:
  - Link drop wins over a terminal count or over the last ack.
  - A timeout and the last ack arriving in the same cycle count as success.
- Counters are 32-bit. Counters for both SLOT and CONFIG reset to 0 on every state entry.

Optional Feature:
- Macro: SLOT_SCHED_STAT_EN.
- When defined:
  - adds outputs o_slot_cnt (32-bit, +1 on each SLOT entry, wraps at 2^32) and o_err_cnt (16-bit, saturating, +1 per o_err);
  - both clear on i_rst only.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package ocs_ctrl_pkg:
  - state enum (IDLE/SYNC/SLOT/CONFIG);
  - sync-type constants SYNC_TIME=1'b0, SYNC_START=1'b1;
  - default timing localparams.
- One natural sub-module: ocs_sync_collector. It owns per-channel request set/clear, all-acked detection and the timeout counter; the top keeps the FSM and slot counters.

Test Plan (P_CHANNEL_NUM=4, P_SLOT_LEN=20, P_CONFIG_DELAY=5, P_LINK_STABLE=8, P_SLOT_NUM=2, P_SYNC_TIMEOUT=32):
- Link-up start: links 4'hF from cycle 10 → o_sync_req=4'hF with o_sync_type=1 at cycle 18. Ack all in the next cycle → o_slot_active high for exactly 20 cycles, then o_ocs_cfg high for exactly 5 cycles, o_slot_id 0→1 on CONFIG entry.
- Steady state: two further periods with immediate acks → second sync has o_sync_type=0; o_slot_id sequence is 1,0,1 (wraps).
- Staggered acks: channel 2 acks 10 cycles after the others → o_sync_req = 4'b0100 until that ack; SLOT starts exactly 1 cycle after it.
- Timeout: channel 3 never acks → o_err pulses 32 cycles after SYNC entry; state returns to IDLE; o_sync_req=0.
- Link drop: drop link 1 mid-SLOT → next cycle o_slot_active=0 and o_err pulse, o_slot_id held. Restore the link → after 8 cycles a type-0 sync is issued.
- Reset mid-CONFIG: assert i_rst for 1 cycle → all outputs 0 on the following edge; the restart issues a type-1 sync. With SLOT_SCHED_STAT_EN defined, o_slot_cnt=0 after reset.
